// File: rtl/fetch_pc_bpu_pkg.sv
// Shared constants and types for the fetch PC generator and its branch target buffer.
// Holds the counter encoding and the saturating counter step used by the BTB.
package fetch_pc_bpu_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_3000;
  localparam logic [31:0] INST_BYTES  = 32'd4;
  localparam int          BTB_ENTRIES = 64;
  localparam int          IDX_W       = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  function automatic cnt_t cnt_step(input cnt_t cur, input logic taken);
    cnt_t res;
    res = cur;
    if (taken && cur != ST) begin
      res = cnt_t'(cur + 2'd1);
    end else if (!taken && cur != SNT) begin
      res = cnt_t'(cur - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_pc_bpu_if.sv
// Fetch-side and EX-resolution signals of the PC generator bundled as one interface.
// master = the PC generator itself; slave = hazard unit / EX / IF-ID side.
interface fetch_pc_bpu_if;
  logic        fStall;
  logic [31:0] pc_f;
  logic        br_pred_f;
  logic        ex_br_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred;
  logic        mispredict;

  modport master (
    input  fStall, ex_br_valid, ex_pc, ex_taken, ex_target, ex_pred,
    output pc_f, br_pred_f, mispredict
  );

  modport slave (
    output fStall, ex_br_valid, ex_pc, ex_taken, ex_target, ex_pred,
    input  pc_f, br_pred_f, mispredict
  );
endinterface

// File: rtl/fetch_pc_bpu_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational read on the fetch PC,
// clocked write from branch resolution. Reads always see pre-write contents.
module bpu_btb
  import fetch_pc_bpu_pkg::*;
#(
  parameter int BTB_ENTRIES = fetch_pc_bpu_pkg::BTB_ENTRIES,
  parameter int IDX_W       = fetch_pc_bpu_pkg::IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic        rd_taken,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic        wr_taken,
  input  logic [31:0] wr_target
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_reg  [BTB_ENTRIES];
  cnt_t             cnt_reg    [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_reg    [BTB_ENTRIES];
  logic [31:0]      target_reg [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             wr_hit;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[31:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[31:IDX_W+2];

  assign rd_hit    = valid_reg[rd_idx] && (tag_reg[rd_idx] == rd_tag);
  assign rd_taken  = cnt_reg[rd_idx][1];
  assign rd_target = target_reg[rd_idx];
  assign wr_hit    = valid_reg[wr_idx] && (tag_reg[wr_idx] == wr_tag);

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      // Only valid and counter state needs reset; tag/target are don't-care while invalid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          cnt_reg[gi]   <= WNT;
        end else if (wr_en && wr_idx == IDX_W'(gi)) begin
          if (wr_hit) begin
            cnt_reg[gi] <= cnt_step(cnt_reg[gi], wr_taken);
          end else if (wr_taken) begin
            valid_reg[gi] <= 1'b1;
            cnt_reg[gi]   <= WT;
          end
        end
      end

      // Taken outcomes rewrite the target on a hit and allocate on a miss;
      // rewriting the tag on a hit is a no-op.
      always_ff @(posedge clk) begin
        if (wr_en && wr_taken && wr_idx == IDX_W'(gi)) begin
          tag_reg[gi]    <= wr_tag;
          target_reg[gi] <= wr_target;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fetch_pc_bpu.sv
// IF-stage PC generator: PC register, next-PC selection and mispredict detection,
// with a direct-mapped BTB supplying 0-cycle taken predictions.
module fetch_pc_bpu
  import fetch_pc_bpu_pkg::*;
#(
  parameter int          BTB_ENTRIES = fetch_pc_bpu_pkg::BTB_ENTRIES,
  parameter int          IDX_W       = fetch_pc_bpu_pkg::IDX_W,
  parameter logic [31:0] RESET_PC    = fetch_pc_bpu_pkg::RESET_PC
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_bpu_if.master bus
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] pred_npc, fix_pc;
  logic        lk_hit, lk_taken, pred_taken, mp;
  logic [31:0] lk_target;

  bpu_btb #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pc_reg),
    .rd_hit    (lk_hit),
    .rd_taken  (lk_taken),
    .rd_target (lk_target),
    .wr_en     (bus.ex_br_valid),
    .wr_pc     (bus.ex_pc),
    .wr_taken  (bus.ex_taken),
    .wr_target (bus.ex_target)
  );

  assign pred_taken = lk_hit && lk_taken;
  assign pred_npc   = pred_taken ? lk_target : pc_reg + INST_BYTES;
  assign mp         = bus.ex_br_valid && (bus.ex_taken != bus.ex_pred);
  assign fix_pc     = bus.ex_taken ? bus.ex_target : bus.ex_pc + INST_BYTES;

  always_comb begin
    pc_next = pred_npc;
    if (mp) begin
      pc_next = fix_pc;
    end else if (bus.fStall) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Outputs are forced quiet for the whole time reset is held, not just after an edge.
  assign bus.pc_f       = pc_reg;
  assign bus.br_pred_f  = pred_taken && !rst;
  assign bus.mispredict = mp && !rst;

endmodule

// File: tb/tb_fetch_pc_bpu.sv
// Bench for fetch_pc_bpu: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of PC and BTB.
module tb_fetch_pc_bpu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_bpu_if bus ();

  fetch_pc_bpu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // Model: each entry remembers the whole branch word address it belongs to.
  bit          m_valid [64];
  logic [31:0] m_addr  [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  logic [31:0] m_pc;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[slot(a)] && ((m_addr[slot(a)] >> 2) == (a >> 2));
  endfunction

  function automatic bit m_pred(input logic [31:0] a);
    return m_hit(a) && (m_cnt[slot(a)] >= 2);
  endfunction

  function automatic bit m_misp();
    return bus.ex_br_valid && (bus.ex_taken != bus.ex_pred);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_pc = 32'h3000;
  endtask

  task automatic model_advance();
    logic [31:0] npc;
    int s;
    if (rst) return;
    if (m_misp())
      npc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
    else if (bus.fStall)
      npc = m_pc;
    else
      npc = m_pred(m_pc) ? m_tgt[slot(m_pc)] : m_pc + 32'd4;
    if (bus.ex_br_valid) begin
      s = slot(bus.ex_pc);
      if (m_hit(bus.ex_pc)) begin
        m_cnt[s] = bus.ex_taken ? ((m_cnt[s] < 3) ? m_cnt[s] + 1 : 3)
                                : ((m_cnt[s] > 0) ? m_cnt[s] - 1 : 0);
        if (bus.ex_taken) m_tgt[s] = bus.ex_target;
      end else if (bus.ex_taken) begin
        m_valid[s] = 1'b1;
        m_addr[s]  = bus.ex_pc;
        m_tgt[s]   = bus.ex_target;
        m_cnt[s]   = 2;
      end
    end
    m_pc = npc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, mid-cycle.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_f",       bus.pc_f,              rst ? 32'h3000 : m_pc);
      check("br_pred_f",  32'(bus.br_pred_f),    32'(!rst && m_pred(m_pc)));
      check("mispredict", 32'(bus.mispredict),   32'(!rst && m_misp()));
    end
  end

  task automatic step();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic pr);
    bus.ex_br_valid = 1'b1;
    bus.ex_pc       = pc;
    bus.ex_taken    = tk;
    bus.ex_target   = tgt;
    bus.ex_pred     = pr;
    #1;
  endtask

  task automatic idle();
    bus.ex_br_valid = 1'b0;
    bus.fStall      = 1'b0;
    bus.ex_taken    = 1'b0;
    bus.ex_pred     = 1'b0;
    bus.ex_pc       = 32'h0;
    bus.ex_target   = 32'h0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    chk_en = 1'b1;
    apply_reset();

    // 1: reset value and free run
    #1;
    check("t1 pc reset", bus.pc_f, 32'h3000);
    check("t1 pred reset", 32'(bus.br_pred_f), 32'd0);
    step(); check("t1 pc +4", bus.pc_f, 32'h3004);
    step(); check("t1 pc +8", bus.pc_f, 32'h3008);

    // 2: cold loop branch 0x3010 -> 0x3000
    resolve(32'h3010, 1'b1, 32'h3000, 1'b0);
    check("t2 mispredict", 32'(bus.mispredict), 32'd1);
    step(); idle(); #1;
    check("t2 redirect", bus.pc_f, 32'h3000);
    check("t2 model cnt", 32'(m_cnt[4]), 32'd2);
    repeat (4) step();
    check("t2 fetch pc", bus.pc_f, 32'h3010);
    check("t2 predicted", 32'(bus.br_pred_f), 32'd1);
    step();
    check("t2 predicted npc", bus.pc_f, 32'h3000);

    // 3: saturation and a single not-taken
    repeat (3) begin
      resolve(32'h3010, 1'b1, 32'h3000, 1'b1);
      step();
    end
    idle(); #1;
    check("t3 model cnt sat", 32'(m_cnt[4]), 32'd3);
    resolve(32'h3010, 1'b0, 32'h3000, 1'b1);
    check("t3 mispredict", 32'(bus.mispredict), 32'd1);
    step(); idle(); #1;
    check("t3 fix pc", bus.pc_f, 32'h3014);
    check("t3 model cnt", 32'(m_cnt[4]), 32'd2);
    check("t3 still taken", 32'(m_pred(32'h3010)), 32'd1);

    // 4: alias 0x3110 evicts 0x3010
    resolve(32'h3110, 1'b1, 32'h3200, 1'b0);
    step(); idle(); #1;
    check("t4 alias redirect", bus.pc_f, 32'h3200);
    resolve(32'h300c, 1'b0, 32'h0, 1'b1);
    step(); idle(); #1;
    check("t4 fetch 3010", bus.pc_f, 32'h3010);
    check("t4 tag miss", 32'(bus.br_pred_f), 32'd0);

    // 5: mispredict beats stall; stall alone holds
    bus.fStall = 1'b1;
    resolve(32'h3040, 1'b1, 32'h3080, 1'b0);
    step();
    bus.ex_br_valid = 1'b0; #1;
    check("t5 mp over stall", bus.pc_f, 32'h3080);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5 stall hold", bus.pc_f, 32'h3080);
    end
    idle();

    // 6: async reset with mispredict pending
    step();
    resolve(32'h3050, 1'b1, 32'h3400, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6 pc async", bus.pc_f, 32'h3000);
    check("t6 mp quiet", 32'(bus.mispredict), 32'd0);
    check("t6 pred quiet", 32'(bus.br_pred_f), 32'd0);
    step(); idle();
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("t6 cold pred", 32'(bus.br_pred_f), 32'd0);
      step();
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] p;
      case ($urandom_range(0, 3))
        0: p = 32'h3000 + ($urandom_range(0, 31) << 2);
        1: p = 32'h3100 + ($urandom_range(0, 31) << 2);
        2: p = m_pc;
        default: p = $urandom() & 32'hffff_fffc;
      endcase
      bus.ex_br_valid = ($urandom_range(0, 2) != 0);
      bus.ex_pc       = p;
      bus.ex_taken    = $urandom_range(0, 1);
      bus.ex_target   = 32'h3000 + ($urandom_range(0, 127) << 2);
      bus.ex_pred     = $urandom_range(0, 1) ? m_pred(p) : 1'($urandom_range(0, 1));
      bus.fStall      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
